// File: rtl/gpi_if.sv
// GPI register bus: single-cycle request, one response on the next cycle.
// Master drives requests, slave (the GPI block) returns responses.
interface gpi_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic                    gpi_req_i;
  logic [AddressWidth-1:0] gpi_addr_i;
  logic                    gpi_we_i;
  logic [DataWidth/8-1:0]  gpi_be_i;
  logic [DataWidth-1:0]    gpi_wdata_i;
  logic                    gpi_rvalid_o;
  logic [DataWidth-1:0]    gpi_rdata_o;
  logic                    gpi_err_o;

  modport master (
    output gpi_req_i,
    output gpi_addr_i,
    output gpi_we_i,
    output gpi_be_i,
    output gpi_wdata_i,
    input  gpi_rvalid_o,
    input  gpi_rdata_o,
    input  gpi_err_o
  );

  modport slave (
    input  gpi_req_i,
    input  gpi_addr_i,
    input  gpi_we_i,
    input  gpi_be_i,
    input  gpi_wdata_i,
    output gpi_rvalid_o,
    output gpi_rdata_o,
    output gpi_err_o
  );
endinterface

// File: rtl/gpi.sv
// General-purpose input block: synchronized pins, edge detect,
// sticky W1C status with per-pin rise/fall enables and level interrupt.
module gpi #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] gpi_i,
  gpi_if.slave                 bus,
  output logic                 gpi_intr_o
);

  localparam int NumBytes = DataWidth / 8;

  logic [DataWidth-1:0] sync1_q;
  logic [DataWidth-1:0] sync2_q;
  logic [DataWidth-1:0] prev_q;
  logic [DataWidth-1:0] rise_en_q;
  logic [DataWidth-1:0] fall_en_q;
  logic [DataWidth-1:0] status_q;
  logic [DataWidth-1:0] status_d;
  logic [DataWidth-1:0] evt;
  logic [DataWidth-1:0] be_mask;
  logic [DataWidth-1:0] wmask;
  logic [DataWidth-1:0] clr;
  logic [DataWidth-1:0] rd_val;
  logic [DataWidth-1:0] rdata_q;
  logic                 rvalid_q;
  logic                 err_q;
  logic                 intr_q;

  logic [3:0] addr;
  logic       is_in;
  logic       is_rise;
  logic       is_fall;
  logic       is_stat;
  logic       bad;
  logic       wr_ok;
  logic       rd_ok;

  // Address bits above the 4-bit window alias onto the same registers.
  logic unused_addr;
  assign unused_addr = ^bus.gpi_addr_i[AddressWidth-1:4];

  assign addr    = bus.gpi_addr_i[3:0];
  assign is_in   = (addr[3:2] == 2'd0);
  assign is_rise = (addr[3:2] == 2'd1);
  assign is_fall = (addr[3:2] == 2'd2);
  assign is_stat = (addr[3:2] == 2'd3);

  assign bad = (addr[1:0] != 2'd0)
             | (bus.gpi_we_i & is_in)
             | (bus.gpi_we_i & (bus.gpi_be_i == '0));

  assign wr_ok = bus.gpi_req_i & bus.gpi_we_i & ~bad;
  assign rd_ok = bus.gpi_req_i & ~bus.gpi_we_i & ~bad;

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < NumBytes; b++) begin
      be_mask[8*b +: 8] = {8{bus.gpi_be_i[b]}};
    end
  end

  assign wmask = bus.gpi_wdata_i & be_mask;

  assign evt = (sync2_q & ~prev_q & rise_en_q)
             | (~sync2_q & prev_q & fall_en_q);

  assign clr = (wr_ok & is_stat) ? wmask : '0;

  // Edge events applied after the clear so a same-cycle set wins.
  assign status_d = (status_q & ~clr) | evt;

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_in:   rd_val = sync2_q;
      is_rise: rd_val = rise_en_q;
      is_fall: rd_val = fall_en_q;
      is_stat: rd_val = status_q;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= gpi_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      intr_q    <= 1'b0;
    end else begin
      if (wr_ok & is_rise) begin
        rise_en_q <= (rise_en_q & ~be_mask) | wmask;
      end
      if (wr_ok & is_fall) begin
        fall_en_q <= (fall_en_q & ~be_mask) | wmask;
      end
      status_q <= status_d;
      intr_q   <= |status_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= bus.gpi_req_i;
      rdata_q  <= rd_ok ? rd_val : '0;
      err_q    <= bus.gpi_req_i & bad;
    end
  end

  assign bus.gpi_rvalid_o = rvalid_q;
  assign bus.gpi_rdata_o  = rdata_q;
  assign bus.gpi_err_o    = err_q;
  assign gpi_intr_o       = intr_q;

endmodule

// File: tb/tb_gpi.sv
// Randomized bench for gpi against a delay-line / register-file model,
// plus directed scenarios with hand-computed expectations.
module tb_gpi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pins = '0;
  logic        intr;

  always #5 clk = ~clk;

  gpi_if bus ();

  gpi dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .gpi_i      (pins),
    .bus        (bus.slave),
    .gpi_intr_o (intr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pin samples from the last three edges, register file,
  // and the response expected after the most recent edge.
  logic [31:0] m_pin [3];
  logic [31:0] m_rise, m_fall, m_stat;
  logic        e_rvalid, e_err;
  logic [31:0] e_rdata;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 3; i++) m_pin[i] = '0;
    m_rise = '0;
    m_fall = '0;
    m_stat = '0;
    e_rvalid = 1'b0;
    e_err = 1'b0;
    e_rdata = '0;
  endtask

  function automatic logic [31:0] bytes_of(logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  // Advance one clock: predict from current inputs, commit at the edge.
  task automatic cycle();
    logic [31:0] in_now, old, ev, mask, clr;
    logic [31:0] n_rise, n_fall, n_stat, n_rdata;
    logic [3:0]  a;
    logic        req, we, bad;
    in_now = m_pin[1];
    old    = m_pin[2];
    ev = '0;
    for (int i = 0; i < 32; i++) begin
      if (in_now[i] && !old[i] && m_rise[i]) ev[i] = 1'b1;
      if (!in_now[i] && old[i] && m_fall[i]) ev[i] = 1'b1;
    end
    a    = bus.gpi_addr_i[3:0];
    req  = bus.gpi_req_i;
    we   = bus.gpi_we_i;
    mask = bytes_of(bus.gpi_be_i);
    bad  = (a % 4 != 0) || (we && (a == 0 || bus.gpi_be_i == 0));
    n_rise = m_rise;
    n_fall = m_fall;
    clr = '0;
    n_rdata = '0;
    if (req && !bad && !we) begin
      case (a)
        4'h0: n_rdata = in_now;
        4'h4: n_rdata = m_rise;
        4'h8: n_rdata = m_fall;
        default: n_rdata = m_stat;
      endcase
    end
    if (req && !bad && we) begin
      case (a)
        4'h4: n_rise = (m_rise & ~mask) | (bus.gpi_wdata_i & mask);
        4'h8: n_fall = (m_fall & ~mask) | (bus.gpi_wdata_i & mask);
        default: clr = bus.gpi_wdata_i & mask;
      endcase
    end
    n_stat = (m_stat & ~clr) | ev;
    @(posedge clk);
    if (rst_n) begin
      m_pin[2] = m_pin[1];
      m_pin[1] = m_pin[0];
      m_pin[0] = pins;
      m_rise = n_rise;
      m_fall = n_fall;
      m_stat = n_stat;
      e_rvalid = req;
      e_err = req && bad;
      e_rdata = n_rdata;
    end else begin
      model_zero();
    end
    #1;
  endtask

  always @(negedge clk) begin
    check("rvalid", {31'b0, bus.gpi_rvalid_o}, {31'b0, e_rvalid});
    check("rdata", bus.gpi_rdata_o, e_rdata);
    check("err", {31'b0, bus.gpi_err_o}, {31'b0, e_err});
    check("intr", {31'b0, intr}, {31'b0, |m_stat});
  end

  task automatic idle(int n);
    bus.gpi_req_i = 1'b0;
    bus.gpi_we_i = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic xact(input logic we, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] d, output logic e);
    bus.gpi_req_i = 1'b1;
    bus.gpi_we_i = we;
    bus.gpi_addr_i = a;
    bus.gpi_be_i = be;
    bus.gpi_wdata_i = wd;
    cycle();
    bus.gpi_req_i = 1'b0;
    bus.gpi_we_i = 1'b0;
    @(negedge clk);
    d = bus.gpi_rdata_o;
    e = bus.gpi_err_o;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, r, a;
    logic        e, got;
    int          pick;
    model_zero();
    bus.gpi_req_i = 1'b0;
    bus.gpi_we_i = 1'b0;
    bus.gpi_addr_i = '0;
    bus.gpi_be_i = '0;
    bus.gpi_wdata_i = '0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    pins = 32'hA5A5_0000;
    idle(3);
    xact(1'b0, 32'h0, 4'h0, 32'h0, d, e);
    check("in_read", d, 32'hA5A5_0000);
    check("in_err", {31'b0, e}, 32'h0);

    xact(1'b1, 32'h4, 4'hF, 32'h1, d, e);
    pins[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      @(negedge clk);
      if (intr) got = 1'b1;
    end
    check("intr_by_4th_edge", {31'b0, got}, 32'h1);
    xact(1'b0, 32'hC, 4'h0, 32'h0, d, e);
    check("status_rise0", d, 32'h1);
    xact(1'b1, 32'hC, 4'hF, 32'h1, d, e);
    check("intr_cleared", {31'b0, intr}, 32'h0);
    xact(1'b0, 32'hC, 4'h0, 32'h0, d, e);
    check("status_cleared", d, 32'h0);

    xact(1'b1, 32'h8, 4'hF, 32'h8000_0000, d, e);
    pins[31] = 1'b0;
    idle(2);
    xact(1'b1, 32'hC, 4'hF, 32'h8000_0000, d, e);
    xact(1'b0, 32'hC, 4'h0, 32'h0, d, e);
    check("set_beats_clear", d, 32'h8000_0000);

    xact(1'b1, 32'h4, 4'hF, 32'h0, d, e);
    xact(1'b1, 32'h4, 4'h2, 32'hFFFF_FFFF, d, e);
    check("wr_rdata", d, 32'h0);
    xact(1'b0, 32'h4, 4'h0, 32'h0, d, e);
    check("byte_enable", d, 32'h0000_FF00);

    xact(1'b1, 32'h0, 4'hF, 32'h1234, d, e);
    check("wr_in_err", {31'b0, e}, 32'h1);
    check("wr_in_rdata", d, 32'h0);
    xact(1'b0, 32'h2, 4'h0, 32'h0, d, e);
    check("misalign_err", {31'b0, e}, 32'h1);
    xact(1'b1, 32'h4, 4'h0, 32'hFFFF_FFFF, d, e);
    check("be0_err", {31'b0, e}, 32'h1);
    xact(1'b0, 32'h4, 4'h0, 32'h0, d, e);
    check("rise_unchanged", d, 32'h0000_FF00);
    xact(1'b1, 32'h8, 4'hF, 32'h0, d, e);
    xact(1'b0, 32'hC, 4'h0, 32'h0, d, e);
    check("en_clear_keeps", d, 32'h8000_0000);

    bus.gpi_req_i = 1'b1;
    bus.gpi_we_i = 1'b0;
    bus.gpi_addr_i = 32'h4;
    cycle();
    bus.gpi_addr_i = 32'h8;
    cycle();
    bus.gpi_addr_i = 32'hC;
    cycle();
    idle(1);

    bus.gpi_req_i = 1'b1;
    bus.gpi_addr_i = 32'h4;
    cycle();
    bus.gpi_addr_i = 32'h8;
    rst_n = 1'b0;
    model_zero();
    pins = 32'hFFFF_FFFF;
    cycle();
    cycle();
    rst_n = 1'b1;
    idle(5);
    xact(1'b0, 32'hC, 4'h0, 32'h0, d, e);
    check("rst_status", d, 32'h0);
    xact(1'b0, 32'h4, 4'h0, 32'h0, d, e);
    check("rst_rise", d, 32'h0);
    xact(1'b0, 32'h8, 4'h0, 32'h0, d, e);
    check("rst_fall", d, 32'h0);
    xact(1'b0, 32'hF000_0000, 4'h0, 32'h0, d, e);
    check("alias_in", d, 32'hFFFF_FFFF);

    for (int n = 0; n < 4000; n++) begin
      r = $urandom();
      if (r[2:0] == 3'd0) pins = pins ^ ($urandom() & $urandom());
      r = $urandom();
      pick = int'(r[3:0]);
      a = $urandom();
      if (pick < 14) a[3:0] = {r[5:4], 2'b00};
      bus.gpi_req_i = r[8];
      bus.gpi_we_i = r[9];
      bus.gpi_addr_i = a;
      bus.gpi_be_i = (r[13:10] == 4'd0) ? 4'h0 : r[17:14];
      bus.gpi_wdata_i = $urandom();
      if (r[31:22] == 10'd0) begin
        rst_n = 1'b0;
        model_zero();
        cycle();
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
